// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage M-extension unit.
//   F3_*    : RV32M funct3 encodings
//   state_t : multiply/divide sequencer states
package cpu_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: magnitude extraction on the way in,
// sign restoration on the way out.
//   val : input value
//   neg : negate when set
//   res : val or -val
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M multiply/divide unit. Accepts one op per in_valid/in_ready
// handshake, iterates one bit per cycle (shift-add multiply, restoring divide)
// and presents result + rd through an out_valid/out_ready handshake.
// in_ready is low while busy so hazard logic can stall the front end.
//   clk, Reset_n          : clock, synchronous active-low reset
//   flush                 : aborts an op in IDLE/CALC; ignored in DONE
//   in_valid/in_ready     : ID/EX handshake
//   funct3, rs1Data,
//   rs2Data, rdAddr_in    : op, operands, destination register
//   out_valid/out_ready   : EX/MEM handshake
//   result, rdAddr_out    : computed value and its destination
// Macro MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle combinational
// multiplier; divides stay iterative.
module ex_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1Data,
  input  logic [XLEN-1:0]   rs2Data,
  input  logic [ADDR_W-1:0] rdAddr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic [ADDR_W-1:0] rdAddr_out
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned PW    = 2 * XLEN;

  state_t            state, state_d;
  logic [CNT_W-1:0]  count;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] rd_q;
  logic              sa_q, sb_q, dz_q, fast_q;
  // op_q: multiplicand (MUL) or divisor (DIV); hi/lo: product or {rem, quotient}
  logic [XLEN-1:0]   op_q, hi_q, lo_q;

  logic              sa_c, sb_c, accept_c, is_div_c, last_c, fast_c;
  logic [XLEN-1:0]   mag_a_c, mag_b_c;
  logic [XLEN:0]     mul_sum_c, div_shift_c, div_diff_c;
  logic [PW-1:0]     fix_in_c, fix_out_c;
  logic              fix_neg_c;
  logic [XLEN-1:0]   res_c;

  // Which operands are treated as signed for this funct3
  always_comb begin
    sa_c = 1'b0;
    sb_c = 1'b0;
    case (funct3)
      F3_MULH: begin
        sa_c = rs1Data[XLEN-1];
        sb_c = rs2Data[XLEN-1];
      end
      F3_MULHSU: sa_c = rs1Data[XLEN-1];
      F3_DIV, F3_REM: begin
        sa_c = rs1Data[XLEN-1];
        sb_c = rs2Data[XLEN-1];
      end
      default: ;
    endcase
  end

  assign is_div_c = funct3[2];
  assign accept_c = (state == S_IDLE) && in_valid && !flush;

  muldiv_signfix #(.W(XLEN)) u_mag_a (.val(rs1Data), .neg(sa_c), .res(mag_a_c));
  muldiv_signfix #(.W(XLEN)) u_mag_b (.val(rs2Data), .neg(sb_c), .res(mag_b_c));

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0] fast_prod_c;
  assign fast_c      = !is_div_c;
  assign fast_prod_c = PW'(mag_a_c) * PW'(mag_b_c);
`else
  assign fast_c = 1'b0;
`endif

  // One iteration of each algorithm
  assign mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
  assign div_shift_c = {hi_q, lo_q[XLEN-1]};
  assign div_diff_c  = div_shift_c - {1'b0, op_q};

  // Final CALC cycle: after XLEN iterations, or immediately for a fast multiply
  assign last_c = fast_q || (count == CNT_W'(XLEN));

  // Pick the magnitude to re-sign; remainder follows the dividend's sign
  always_comb begin
    fix_in_c  = {hi_q, lo_q};
    fix_neg_c = sa_q ^ sb_q;
    case (f3_q)
      F3_DIV, F3_DIVU: fix_in_c = {{XLEN{1'b0}}, lo_q};
      F3_REM, F3_REMU: begin
        fix_in_c  = {{XLEN{1'b0}}, hi_q};
        fix_neg_c = sa_q;
      end
      default: ;
    endcase
  end

  muldiv_signfix #(.W(PW)) u_res (.val(fix_in_c), .neg(fix_neg_c), .res(fix_out_c));

  // Result select; divide-by-zero quotient is forced to all ones
  always_comb begin
    res_c = fix_out_c[PW-1:XLEN];
    case (f3_q)
      F3_MUL:          res_c = fix_out_c[XLEN-1:0];
      F3_DIV, F3_DIVU: res_c = dz_q ? '1 : fix_out_c[XLEN-1:0];
      F3_REM, F3_REMU: res_c = fix_out_c[XLEN-1:0];
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept_c) state_d = S_CALC;
      S_CALC: begin
        if (flush)       state_d = S_IDLE;
        else if (last_c) state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, handshake outputs and datapath registers
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      rdAddr_out <= '0;
      count      <= '0;
      f3_q       <= F3_MUL;
      rd_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      fast_q     <= 1'b0;
      op_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == S_IDLE);
      out_valid <= (state_d == S_DONE);

      if (accept_c) begin
        f3_q   <= funct3;
        rd_q   <= rdAddr_in;
        sa_q   <= sa_c;
        sb_q   <= sb_c;
        dz_q   <= (rs2Data == '0);
        fast_q <= fast_c;
        count  <= '0;
        op_q   <= is_div_c ? mag_b_c : mag_a_c;
        hi_q   <= '0;
        lo_q   <= is_div_c ? mag_a_c : mag_b_c;
`ifdef MULDIV_FAST_MUL_EN
        if (fast_c) {hi_q, lo_q} <= fast_prod_c;
`endif
      end else if (state == S_CALC && !last_c) begin
        count <= count + CNT_W'(1);
        if (f3_q[2]) begin
          // Restoring step: keep the difference only when it is non-negative
          if (!div_diff_c[XLEN]) begin
            hi_q <= div_diff_c[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_q <= div_shift_c[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          {hi_q, lo_q} <= {mul_sum_c, lo_q[XLEN-1:1]};
        end
      end

      if (state == S_CALC && !flush && last_c) begin
        result     <= res_c;
        rdAddr_out <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random
// ops checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1Data = '0;
  logic [31:0] rs2Data = '0;
  logic [4:0]  rdAddr_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [4:0]  rdAddr_out;

  int tests = 0;
  int fails = 0;

  ex_muldiv_unit #(.XLEN(32), .ADDR_W(5)) dut (
    .clk(clk), .Reset_n(Reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1Data(rs1Data), .rs2Data(rs2Data), .rdAddr_in(rdAddr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rdAddr_out(rdAddr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics from 64-bit integer arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'h0, a});
    longint      ub = longint'({32'h0, b});
    logic [63:0] p;
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f);
`ifdef MULDIV_FAST_MUL_EN
    return f[2] ? 33 : 1;
`else
    return (f == 3'd7) ? 33 : 33;
`endif
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(0, 20));
      default: v = 32'($urandom());
    endcase
    return v;
  endfunction

  // Present an op and hold it through the accepting edge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    funct3 = f; rs1Data = a; rs2Data = b; rdAddr_in = rd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges from the accept edge until out_valid is seen (bounded)
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 60) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic run_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int cyc;
    issue(f, a, b, rd);
    wait_out(cyc);
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat(f)));
    check({tag, "_res"}, result, exp);
    check({tag, "_rd"}, 32'(rdAddr_out), 32'(rd));
    @(posedge clk); #1;
  endtask

  initial begin
    int  cyc;
    bit  seen;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rdAddr_out), 32'd0);
    Reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic corners
    run_check("mul",       3'd0, 32'd7,          32'hFFFF_FFFD, 5'd13, 32'hFFFF_FFEB);
    run_check("mulhu",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE);
    run_check("mulh",      3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000);
    run_check("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF);
    run_check("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd4,  32'h8000_0000);
    run_check("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000);
    run_check("div_neg",   3'd4, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFD);
    run_check("rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFF);
    run_check("divu_z",    3'd5, 32'd100,        32'd0,         5'd8,  32'hFFFF_FFFF);
    run_check("remu_z",    3'd7, 32'd100,        32'd0,         5'd9,  32'd100);
    run_check("div_z_neg", 3'd4, 32'hFFFF_FFFB,  32'd0,         5'd10, 32'hFFFF_FFFF);
    run_check("rem_z_neg", 3'd6, 32'hFFFF_FFFB,  32'd0,         5'd11, 32'hFFFF_FFFB);

    // Back-pressure in DONE: outputs held, flush ignored, next op waits
    out_ready = 1'b0;
    issue(3'd0, 32'd3, 32'd5, 5'd7);
    wait_out(cyc);
    check("bp_lat", 32'(cyc), 32'(exp_lat(3'd0)));
    funct3 = 3'd5; rs1Data = 32'd1000; rs2Data = 32'd7; rdAddr_in = 5'd9; in_valid = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_res", result, 32'd15);
      check("bp_rd", 32'(rdAddr_out), 32'd7);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_retire_ov", 32'(out_valid), 32'd0);
    check("bp_retire_ir", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_acc", 32'(in_ready), 32'd0);
    wait_out(cyc);
    check("bp_next_lat", 32'(cyc), 32'(exp_lat(3'd5)));
    check("bp_next_res", result, 32'd142);
    check("bp_next_rd", 32'(rdAddr_out), 32'd9);
    @(posedge clk); #1;

    // Flush on the 10th CALC cycle drops the op
    issue(3'd4, 32'd1000, 32'd3, 5'd4);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_no_out", 32'(seen), 32'd0);

    // Reset mid-CALC
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd22);
    repeat (15) @(posedge clk);
    #1;
    Reset_n = 1'b0;
    @(posedge clk); #1;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_result", result, 32'd0);
    check("mrst_rd", 32'(rdAddr_out), 32'd0);
    Reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("mrst_no_out", 32'(seen), 32'd0);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      rd = 5'($urandom_range(0, 31));
      run_check($sformatf("rand%0d_f%0d", i, f), f, a, b, rd, ref_op(f, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
